// File: rtl/fq_div_prog.sv
// Programmable org_clk divider (N >= 2, odd or even) with period tick and glitch-free ratio changes.
// Latency: outputs registered; first enabled edge after reset/idle starts a period (div_clk=1, tick=1).
// Backpressure: none; load is a single-cycle request, and only the last load before a wrap is applied.
module fq_div_prog #(
  parameter int W       = 16,
  parameter int DEF_DIV = 4
) (
  input  logic         org_clk,
  input  logic         sys_rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div_val,
  output logic         div_clk,
  output logic         tick,
  output logic         load_done,
  output logic [W-1:0] cur_div
);

  localparam logic [W-1:0] RST_DIV = (DEF_DIV < 2) ? W'(2) : W'(DEF_DIV);
  localparam logic [W-1:0] ONE     = W'(1);

  logic [W-1:0] cnt;
  logic [W-1:0] pend;
  logic         pend_v;

  logic [W-1:0] cnt_nxt;
  logic [W-1:0] div_nxt;
  logic [W-1:0] pend_nxt;
  logic [W-1:0] load_val;
  logic         pend_v_nxt;
  logic         done_nxt;
  logic         clk_nxt;
  logic         tick_nxt;
  logic         wrap;

  // High time (N+1)>>1 without needing a W+1 bit adder when N = 2^W-1.
  function automatic logic [W-1:0] high_of(input logic [W-1:0] n);
    return (n >> 1) + {{(W-1){1'b0}}, n[0]};
  endfunction

  always_comb begin
    load_val   = (div_val < W'(2)) ? W'(2) : div_val;
    wrap       = (cnt == cur_div - ONE);
    cnt_nxt    = cnt;
    div_nxt    = cur_div;
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
    done_nxt   = 1'b0;
    clk_nxt    = 1'b0;
    tick_nxt   = 1'b0;

    if (en) begin
      if (wrap) begin
        cnt_nxt = '0;
        if (pend_v) begin
          div_nxt    = pend;
          pend_v_nxt = 1'b0;
          done_nxt   = 1'b1;
        end
      end else begin
        cnt_nxt = cnt + ONE;
      end
      // A load on the applying edge overrides the clear and stays pending for the next wrap.
      if (load) begin
        pend_nxt   = load_val;
        pend_v_nxt = 1'b1;
      end
      clk_nxt  = (cnt_nxt < high_of(div_nxt));
      tick_nxt = (cnt_nxt == '0);
    end else begin
      if (load) begin
        div_nxt    = load_val;
        pend_nxt   = load_val;
        pend_v_nxt = 1'b0;
        done_nxt   = 1'b1;
      end else if (pend_v) begin
        div_nxt    = pend;
        pend_v_nxt = 1'b0;
        done_nxt   = 1'b1;
      end
      // Parking at N-1 makes the first enabled edge a wrap.
      cnt_nxt = div_nxt - ONE;
    end
  end

  always_ff @(posedge org_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt       <= RST_DIV - ONE;
      cur_div   <= RST_DIV;
      pend      <= RST_DIV;
      pend_v    <= 1'b0;
      div_clk   <= 1'b0;
      tick      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      cur_div   <= div_nxt;
      pend      <= pend_nxt;
      pend_v    <= pend_v_nxt;
      div_clk   <= clk_nxt;
      tick      <= tick_nxt;
      load_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fq_div_prog.sv
// Bench for fq_div_prog: period-position reference model compared every cycle, plus literal sequences.
module tb_fq_div_prog;

  localparam int W   = 16;
  localparam int DEF = 4;

  logic         org_clk = 1'b0;
  logic         sys_rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] div_val;
  logic         div_clk;
  logic         tick;
  logic         load_done;
  logic [W-1:0] cur_div;

  int n_chk = 0;
  int n_err = 0;

  fq_div_prog #(.W(W), .DEF_DIV(DEF)) dut (
    .org_clk   (org_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .load      (load),
    .div_val   (div_val),
    .div_clk   (div_clk),
    .tick      (tick),
    .load_done (load_done),
    .cur_div   (cur_div)
  );

  always #5 org_clk = ~org_clk;

  // Reference: ratio in effect, position within the period, optional pending ratio (-1 = none).
  int m_n, m_pos, m_pend;
  bit m_clk, m_tick, m_done;

  function automatic int clamp2(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge org_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_n = DEF; m_pos = DEF - 1; m_pend = -1;
      m_clk = 0; m_tick = 0; m_done = 0;
    end else if (en) begin
      if (m_pos == m_n - 1) begin
        m_pos  = 0;
        m_done = (m_pend >= 0);
        if (m_pend >= 0) begin m_n = m_pend; m_pend = -1; end
      end else begin
        m_pos  = m_pos + 1;
        m_done = 0;
      end
      if (load) m_pend = clamp2(int'(div_val));
      m_clk  = (m_pos < (m_n + 1) / 2);
      m_tick = (m_pos == 0);
    end else begin
      if (load) m_pend = clamp2(int'(div_val));
      m_done = (m_pend >= 0);
      if (m_pend >= 0) begin m_n = m_pend; m_pend = -1; end
      m_pos  = m_n - 1;
      m_clk  = 0;
      m_tick = 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, then compare every output with the model.
  task automatic step();
    @(negedge org_clk);
    chk("model div_clk", int'(div_clk), int'(m_clk));
    chk("model tick", int'(tick), int'(m_tick));
    chk("model load_done", int'(load_done), int'(m_done));
    chk("model cur_div", int'(cur_div), m_n);
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (load_done) begin ok = 1; break; end
    end
  endtask

  logic [7:0] pat_clk, pat_tick;
  logic [6:0] pat2_clk, pat2_done;
  bit         ok;
  int         dcnt, hcnt, lcnt;

  initial begin
    sys_rst_n = 0; en = 0; load = 0; div_val = '0;
    step(); step();
    chk("reset div_clk", int'(div_clk), 0);
    chk("reset tick", int'(tick), 0);
    chk("reset load_done", int'(load_done), 0);
    chk("reset cur_div", int'(cur_div), 4);

    // Default ratio 4: 1,1,0,0 with tick on the very first edge.
    sys_rst_n = 1; en = 1;
    pat_clk = 8'b11001100; pat_tick = 8'b10001000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1 div_clk", int'(div_clk), int'(pat_clk[7-i]));
      chk("t1 tick", int'(tick), int'(pat_tick[7-i]));
    end

    // Mid-period load of 5: current period finishes at 4, then 1,1,1,0,0.
    step();
    load = 1; div_val = 16'd5; step(); load = 0;
    chk("t2 cur_div before wrap", int'(cur_div), 4);
    pat2_clk = 7'b0011100; pat2_done = 7'b0010000;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t2 div_clk", int'(div_clk), int'(pat2_clk[6-i]));
      chk("t2 load_done", int'(load_done), int'(pat2_done[6-i]));
      chk("t2 tick", int'(tick), int'(pat2_done[6-i]));
    end

    // Two loads in one period: last one wins, single load_done.
    step();
    load = 1; div_val = 16'd6; step();
    div_val = 16'd3; step(); load = 0;
    wait_done(10, ok);
    chk("t4 load_done seen", int'(ok), 1);
    chk("t4 cur_div", int'(cur_div), 3);
    dcnt = 0;
    for (int i = 0; i < 9; i++) begin step(); if (load_done) dcnt++; end
    chk("t4 extra load_done", dcnt, 0);

    // Loads of 0 then 1 clamp to 2.
    load = 1; div_val = 16'd0; step();
    div_val = 16'd1; step(); load = 0;
    wait_done(10, ok);
    chk("t3 load_done seen", int'(ok), 1);
    chk("t3 cur_div", int'(cur_div), 2);
    chk("t3 first div_clk", int'(div_clk), 1);
    chk("t3 first tick", int'(tick), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3 div_clk", int'(div_clk), i % 2);
      chk("t3 tick", int'(tick), i % 2);
    end

    // Back to 4, then idle for 3 cycles at cnt=1 and re-enable.
    load = 1; div_val = 16'd4; step(); load = 0;
    wait_done(10, ok);
    chk("t5 load_done seen", int'(ok), 1);
    step();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5 idle div_clk", int'(div_clk), 0);
      chk("t5 idle tick", int'(tick), 0);
    end
    chk("t5 cur_div", int'(cur_div), 4);
    en = 1;
    step(); chk("t5 restart div_clk", int'(div_clk), 1); chk("t5 restart tick", int'(tick), 1);
    step(); chk("t5 second div_clk", int'(div_clk), 1); chk("t5 second tick", int'(tick), 0);
    step(); chk("t5 third div_clk", int'(div_clk), 0);

    for (int c = 0; c < 3000; c++) begin
      en      = ($urandom_range(0, 15) != 0);
      load    = ($urandom_range(0, 9) == 0);
      div_val = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 6));
      step();
    end
    load = 0; en = 1;

    // Async reset in the high phase of a ratio-7 period.
    load = 1; div_val = 16'd7; step(); load = 0;
    wait_done(50, ok);
    chk("t6 load 7 seen", int'(ok), 1);
    chk("t6 cur_div 7", int'(cur_div), 7);
    step();
    chk("t6 high before reset", int'(div_clk), 1);
    sys_rst_n = 0;
    #1;
    chk("t6 async div_clk", int'(div_clk), 0);
    chk("t6 async tick", int'(tick), 0);
    chk("t6 async cur_div", int'(cur_div), 4);
    step(); step();
    sys_rst_n = 1;
    step();
    chk("t6 post-reset div_clk", int'(div_clk), 1);
    chk("t6 post-reset tick", int'(tick), 1);

    // Largest ratio: 32768 high, 32767 low.
    load = 1; div_val = 16'hFFFF; step(); load = 0;
    wait_done(10, ok);
    chk("t7 load 65535 seen", int'(ok), 1);
    chk("t7 cur_div", int'(cur_div), 65535);
    hcnt = 0;
    while (div_clk && hcnt < 70000) begin hcnt++; step(); end
    lcnt = 0;
    while (!tick && lcnt < 70000) begin lcnt++; step(); end
    chk("t7 high cycles", hcnt, 32768);
    chk("t7 low cycles", lcnt, 32767);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
